axi_tx_scheduler: RTL and testbench

Frame-atomic round-robin scheduler that shares the single AXI-stream input of `data_controller` between `NUM_SRC` requesters. It locks onto one source for a whole frame, passes its in-frame bubbles through, and inserts the inter-frame gap that `data_controller`/`lane_controller` require between messages. It also aborts frames whose source stalls too long. It sits directly in front of `data_controller`, in the AXI data clock domain.

---
 rtl/aurora_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_axi_tx_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared types and default constants for the AXI transmit path in front of data_controller.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

package aurora_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } sched_state_e;

    localparam int unsigned SCHED_GAP_MULTI  = 2;
    localparam int unsigned SCHED_GAP_SINGLE = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!gnt_any && req[IW'(cand)]) begin
                gnt_any           = 1'b1;
                gnt_idx           = IW'(cand);
                gnt[IW'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_tx_scheduler.sv
// Frame-atomic round-robin scheduler sharing the data_controller AXI-stream input between sources.
// state | meaning
// IDLE  | no frame owned; arbitrate among valid sources when enabled
// XFER  | forwarding the granted source, bubbles included; stall timer running
// DRAIN | frame aborted; swallow the granted source's beats up to its last
// GAP   | hold off all sources for the inter-frame gap
module axi_tx_scheduler
    import aurora_pkg::*;
#(
    parameter  int unsigned NUM_SRC      = 4,
    parameter  int unsigned DATA_W       = `AXI_DATA_SIZE,
    parameter  int unsigned GAP_MULTI    = SCHED_GAP_MULTI,
    parameter  int unsigned GAP_SINGLE   = SCHED_GAP_SINGLE,
    parameter  int unsigned IDLE_TIMEOUT = 16,
    localparam int unsigned IW           = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             single_lane,
    input  logic                             enable,
    input  logic [NUM_SRC-1:0]               s_valid,
    input  logic [NUM_SRC-1:0]               s_last,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   s_data,
    output logic [NUM_SRC-1:0]               s_ready,
    output logic                             m_valid,
    output logic                             m_last,
    output logic [DATA_W-1:0]                m_data,
    output logic [IW-1:0]                    grant_id,
    output logic                             busy,
    output logic                             abort
);

    localparam int unsigned GAP_MAX = (GAP_MULTI > GAP_SINGLE) ? GAP_MULTI : GAP_SINGLE;
    localparam int unsigned GW      = $clog2(GAP_MAX + 1);
    localparam int unsigned BW      = $clog2(IDLE_TIMEOUT + 1);

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         grant_q;
    logic [BW-1:0]         bub_q, bub_d;
    logic [GW-1:0]         gap_q, gap_d;

    logic [NUM_SRC-1:0]    arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic [NUM_SRC-1:0]    grant_oh;
    logic [IW-1:0]         sel;
    logic                  fwd;
    logic                  abort_d;
    logic                  take_grant;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req     (s_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign grant_oh = NUM_SRC'(1) << grant_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        bub_d      = bub_q;
        gap_d      = gap_q;
        s_ready    = '0;
        sel        = grant_q;
        fwd        = 1'b0;
        abort_d    = 1'b0;
        take_grant = 1'b0;

        case (state_q)
            IDLE: begin
                sel = arb_idx;
                if (enable && arb_any) begin
                    s_ready    = arb_gnt;
                    take_grant = 1'b1;
                    fwd        = 1'b1;
                    bub_d      = '0;
                    state_d    = s_last[arb_idx] ? GAP : XFER;
                end
            end
            XFER: begin
                s_ready = grant_oh;
                if (s_valid[grant_q]) begin
                    fwd   = 1'b1;
                    bub_d = '0;
                    if (s_last[grant_q]) begin
                        state_d = GAP;
                    end
                end else if (bub_q == BW'(IDLE_TIMEOUT - 1)) begin
                    // this bubble is the limit; a beat arriving now would have won instead
                    abort_d = 1'b1;
                    bub_d   = '0;
                    state_d = DRAIN;
                end else begin
                    bub_d = bub_q + 1'b1;
                end
            end
            DRAIN: begin
                s_ready = grant_oh;
                if (s_valid[grant_q] && s_last[grant_q]) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // gap length is latched only on entry so lane-mode changes wait for the next frame boundary
        if (state_d == GAP && state_q != GAP) begin
            gap_d = single_lane ? GW'(GAP_SINGLE - 1) : GW'(GAP_MULTI - 1);
        end

        if (rst) begin
            s_ready = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NUM_SRC - 1);
            grant_q <= '0;
            bub_q   <= '0;
            gap_q   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            abort   <= 1'b0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            gap_q   <= gap_d;
            if (take_grant) begin
                ptr_q   <= arb_idx;
                grant_q <= arb_idx;
            end
            m_valid <= fwd | abort_d;
            m_last  <= abort_d | (fwd & s_last[sel]);
            m_data  <= fwd ? s_data[sel] : '0;
            abort   <= abort_d;
        end
    end

endmodule

// File: tb/tb_axi_tx_scheduler.sv
// Scoreboard bench for axi_tx_scheduler: directed frames with expected beats queued up front.
module tb_axi_tx_scheduler;

    localparam int NS = 4;
    localparam int DW = 64;

    logic                 clk         = 1'b0;
    logic                 rst         = 1'b0;
    logic                 single_lane = 1'b0;
    logic                 enable      = 1'b1;
    logic [NS-1:0]        s_valid     = '0;
    logic [NS-1:0]        s_last      = '0;
    logic [NS-1:0][DW-1:0] s_data     = '0;
    logic [NS-1:0]        s_ready;
    logic                 m_valid;
    logic                 m_last;
    logic [DW-1:0]        m_data;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 abort;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          abrt;
        int            gid;
        int            gap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    logic mon_en   = 1'b1;

    axi_tx_scheduler #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .single_lane (single_lane),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_data      (m_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort       (abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(int gid, logic [31:0] tag, int j, logic last, int gap);
        exp_t x;
        x.data = {tag, 32'(j)};
        x.last = last;
        x.abrt = 1'b0;
        x.gid  = gid;
        x.gap  = gap;
        q.push_back(x);
    endfunction

    function automatic void push_frame(int gid, logic [31:0] tag, int n, int first_gap,
                                       int stall_at, int stall_gap);
        for (int j = 0; j < n; j++)
            push(gid, tag, j, (j == n - 1), (j == 0) ? first_gap : ((j == stall_at) ? stall_gap : 0));
    endfunction

    function automatic void push_abort(int gid, int gap);
        exp_t x;
        x.data = '0;
        x.last = 1'b1;
        x.abrt = 1'b1;
        x.gid  = gid;
        x.gap  = gap;
        q.push_back(x);
    endfunction

    // One source presents n beats {tag, j}; valid drops for stall_len cycles before beat stall_at.
    task automatic send_frame(input int src, input int n, input logic [31:0] tag,
                              input int stall_at, input int stall_len);
        int w;
        for (int j = 0; j < n; j++) begin
            if (j == stall_at) begin
                s_valid[src] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            s_valid[src] = 1'b1;
            s_last[src]  = (j == n - 1);
            s_data[src]  = {tag, 32'(j)};
            w = 0;
            @(negedge clk);
            while (!s_ready[src] && w < 400) begin
                w++;
                @(negedge clk);
            end
            if (!s_ready[src]) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: src %0d beat %0d never accepted", src, j);
                s_valid[src] = 1'b0;
                s_last[src]  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid[src] = 1'b0;
        s_last[src]  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected beats never appeared", q.size());
            q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (m_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data %0h last %0b grant %0d", m_data, m_last, grant_id);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", m_last, e.last);
                    chk("beat_abort", abort, e.abrt);
                    chk("beat_grant", grant_id, e.gid);
                    if (e.gap >= 0) chk("idle_gap", cyc - last_cyc - 1, e.gap);
                end
                last_cyc = cyc;
            end else begin
                chk("idle_abort", abort, 0);
                chk("idle_last", m_last, 0);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #2 s_valid = '1;
        #10;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_grant", grant_id, 0);
        s_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single 3-beat frame from source 0
        push_frame(0, 32'hDEADB00D, 3, -1, -1, 0);
        send_frame(0, 3, 32'hDEADB00D, -1, 0);
        wait_drain();

        // all four contending, source 0 with two frames: grants 0,1,2,3,0 with 2-cycle gaps
        do_reset();
        push_frame(0, 32'hA000_0000, 2, -1, -1, 0);
        push_frame(1, 32'hA000_0001, 2, 2, -1, 0);
        push_frame(2, 32'hA000_0002, 2, 2, -1, 0);
        push_frame(3, 32'hA000_0003, 2, 2, -1, 0);
        push_frame(0, 32'hB000_0000, 2, 2, -1, 0);
        fork
            begin
                send_frame(0, 2, 32'hA000_0000, -1, 0);
                send_frame(0, 2, 32'hB000_0000, -1, 0);
            end
            send_frame(1, 2, 32'hA000_0001, -1, 0);
            send_frame(2, 2, 32'hA000_0002, -1, 0);
            send_frame(3, 2, 32'hA000_0003, -1, 0);
        join
        wait_drain();

        // single-lane mode: 1-cycle gap; pointer sits at 0 so 2 then 3
        single_lane = 1'b1;
        push_frame(2, 32'hC000_0002, 2, -1, -1, 0);
        push_frame(3, 32'hC000_0003, 2, 1, -1, 0);
        fork
            send_frame(2, 2, 32'hC000_0002, -1, 0);
            send_frame(3, 2, 32'hC000_0003, -1, 0);
        join
        wait_drain();
        single_lane = 1'b0;

        // 3 in-frame bubbles are forwarded
        push_frame(1, 32'hC1C1_0001, 7, -1, 2, 3);
        send_frame(1, 7, 32'hC1C1_0001, 2, 3);
        wait_drain();

        // 15 bubbles then a beat: acceptance beats the timeout, no abort
        push_frame(1, 32'hC2C2_0001, 4, -1, 2, 15);
        send_frame(1, 4, 32'hC2C2_0001, 2, 15);
        wait_drain();

        // 16 bubbles: abort beat, rest of the frame dropped, then source 3
        push(2, 32'hD2D2_0002, 0, 1'b0, -1);
        push(2, 32'hD2D2_0002, 1, 1'b0, 0);
        push_abort(2, 15);
        push(3, 32'hD3D3_0003, 0, 1'b1, -1);
        fork
            send_frame(2, 5, 32'hD2D2_0002, 2, 16);
            send_frame(3, 1, 32'hD3D3_0003, -1, 0);
        join
        wait_drain();

        // enable dropped mid-frame: frame completes, source 1 waits for enable
        push_frame(0, 32'hE000_0000, 4, -1, -1, 0);
        fork
            send_frame(0, 4, 32'hE000_0000, -1, 0);
        join_none
        @(posedge clk);
        #1 enable = 1'b0;
        push_frame(1, 32'hE000_0001, 2, -1, -1, 0);
        fork
            send_frame(1, 2, 32'hE000_0001, -1, 0);
        join_none
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("en_block_ready", s_ready, 0);
        chk("en_block_busy", busy, 0);
        chk("en_frame_done", q.size(), 2);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_drain();

        // async reset in the middle of a source 2 frame
        mon_en = 1'b0;
        s_valid[2] = 1'b1;
        s_last[2]  = 1'b0;
        s_data[2]  = 64'h0000_00F6_0000_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_m_valid", m_valid, 1);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_grant", grant_id, 2);
        s_valid[1] = 1'b1;
        s_last[1]  = 1'b1;
        s_data[1]  = 64'h1111_2222_3333_4444;
        s_valid[3] = 1'b1;
        s_last[3]  = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant_id, 0);
        s_valid[2] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("post_rst_grant", grant_id, 1);
        chk("post_rst_m_valid", m_valid, 1);
        chk("post_rst_m_data", m_data, 64'h1111_2222_3333_4444);
        chk("post_rst_m_last", m_last, 1);
        s_valid = '0;
        s_last  = '0;
        repeat (6) @(posedge clk);
        #1 mon_en = 1'b1;

        chk("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
